ad_bus_cycle_seq: RTL and testbench

- Parametrised sequencer for the multiplexed address/data bus.
- Generalises the fixed 12-count write-timing generator:
  - supports both read and write cycles;
  - per-phase widths are parameters;
  - data width is a parameter;
  - uses a start/busy/done handshake;
  - latches address and data, and captures read data.
- Sits between the controller FSM and the external peripheral pins; drives CS, RD, WR, AD, DIR and the output half of the bus.

---
 rtl/ad_bus_pkg.sv | 78 +++++++
 rtl/ad_phase_timer.sv | 35 +++
 rtl/ad_bus_cycle_seq.sv | 187 ++++++++++++++++++
 tb/tb_ad_bus_cycle_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_bus_pkg.sv
// Shared types and helpers for the multiplexed address/data bus sequencer.
package ad_bus_pkg;

  // Bus cycle phases in the order they occur.
  typedef enum logic [2:0] {
    IDLE,
    ADDR_SU,
    ADDR_STB,
    ADDR_HLD,
    TURN,
    DATA_STB,
    DATA_HLD,
    RECOVER
  } ad_state_e;

  // Pin bundle as seen on the peripheral side; strobes are active low.
  typedef struct packed {
    logic cs;
    logic rd;
    logic wr;
    logic ad;
    logic dir;
  } ad_pins_t;

  // Levels the pins rest at whenever no cycle is running.
  localparam logic PIN_CS_OFF  = 1'b1;
  localparam logic PIN_RD_OFF  = 1'b1;
  localparam logic PIN_WR_OFF  = 1'b1;
  localparam logic PIN_AD_OFF  = 1'b1;
  localparam logic PIN_DIR_OFF = 1'b0;

  localparam ad_pins_t PINS_IDLE = '{cs: PIN_CS_OFF, rd: PIN_RD_OFF, wr: PIN_WR_OFF,
                                     ad: PIN_AD_OFF, dir: PIN_DIR_OFF};

  // Cycles from acceptance to acceptance when start is held high; this
  // includes the IDLE cycle that carries the done pulse.
  function automatic int unsigned cycle_len(int unsigned t_as, int unsigned t_ta,
                                            int unsigned t_ds, int unsigned t_rec);
    return 4 + t_as + t_ta + t_ds + t_rec;
  endfunction

  // Largest of the four phase widths, used to size the phase counter.
  function automatic int max4(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Pin levels for a phase; rw only matters once the bus turns around.
  function automatic ad_pins_t pins_for(ad_state_e s, logic rw);
    ad_pins_t p;
    p = PINS_IDLE;
    case (s)
      ADDR_SU, ADDR_HLD: begin
        p.cs = 1'b0; p.rd = 1'b1; p.wr = 1'b1; p.ad = 1'b0; p.dir = 1'b1;
      end
      ADDR_STB: begin
        p.cs = 1'b0; p.rd = 1'b1; p.wr = 1'b0; p.ad = 1'b0; p.dir = 1'b1;
      end
      TURN: begin
        p.cs = 1'b1; p.rd = 1'b1; p.wr = 1'b1; p.ad = 1'b1; p.dir = ~rw;
      end
      DATA_STB: begin
        p.cs = 1'b0; p.ad = 1'b1;
        p.rd = ~rw; p.wr = rw; p.dir = ~rw;
      end
      DATA_HLD: begin
        p.cs = 1'b0; p.rd = 1'b1; p.wr = 1'b1; p.ad = 1'b1; p.dir = ~rw;
      end
      default: p = PINS_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ad_phase_timer.sv
// Loadable down-counter that times how long the sequencer stays in a phase.
module ad_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over counting; the count parks at zero until reloaded.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ad_bus_cycle_seq.sv
// Read/write cycle sequencer for the multiplexed address/data peripheral bus.
// All pin outputs are registered so the pads see glitch-free levels.
module ad_bus_cycle_seq
  import ad_bus_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int T_AS   = 2,
  parameter int T_TA   = 1,
  parameter int T_DS   = 4,
  parameter int T_REC  = 2
) (
  input  logic              clkAD,
  input  logic              resetAD,
  input  logic              start,
  input  logic              rw,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              CS,
  output logic              RD,
  output logic              WR,
  output logic              AD,
  output logic              DIR
);

  localparam int T_MAX = max4(T_AS, T_TA, T_DS, T_REC);
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [CNT_W-1:0] LD_ONE = '0;
  localparam logic [CNT_W-1:0] LD_AS  = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] LD_TA  = CNT_W'(T_TA - 1);
  localparam logic [CNT_W-1:0] LD_DS  = CNT_W'(T_DS - 1);
  localparam logic [CNT_W-1:0] LD_REC = CNT_W'(T_REC - 1);

  if (T_AS < 1 || T_TA < 1 || T_DS < 1 || T_REC < 1) begin : g_bad_timing
    $error("ad_bus_cycle_seq: every phase width must be at least one cycle");
  end

  if (DATA_W < 1) begin : g_bad_width
    $error("ad_bus_cycle_seq: DATA_W must be at least 1");
  end

  ad_state_e           state_q, state_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   bus_out_q, bus_out_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  ad_pins_t            pins_q, pins_d;

  logic                tmr_load;
  logic [CNT_W-1:0]    tmr_val;
  logic                tmr_zero;

  ad_phase_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk      (clkAD),
    .rst      (resetAD),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Next phase, latched request fields and the pin levels of the next phase;
  // every phase change reloads the timer with that phase's width minus one.
  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    bus_out_d = bus_out_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = LD_ONE;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ADDR_SU;
          rw_d      = rw;
          wdata_d   = wdata;
          bus_out_d = addr;
          tmr_load  = 1'b1;
          tmr_val   = LD_ONE;
        end
      end
      ADDR_SU: begin
        if (tmr_zero) begin
          state_d  = ADDR_STB;
          tmr_load = 1'b1;
          tmr_val  = LD_AS;
        end
      end
      ADDR_STB: begin
        if (tmr_zero) begin
          state_d  = ADDR_HLD;
          tmr_load = 1'b1;
          tmr_val  = LD_ONE;
        end
      end
      ADDR_HLD: begin
        if (tmr_zero) begin
          state_d   = TURN;
          bus_out_d = wdata_q;
          tmr_load  = 1'b1;
          tmr_val   = LD_TA;
        end
      end
      TURN: begin
        if (tmr_zero) begin
          state_d  = DATA_STB;
          tmr_load = 1'b1;
          tmr_val  = LD_DS;
        end
      end
      DATA_STB: begin
        if (tmr_zero) begin
          state_d  = DATA_HLD;
          tmr_load = 1'b1;
          tmr_val  = LD_ONE;
          if (rw_q) begin
            rdata_d = bus_in;
          end
        end
      end
      DATA_HLD: begin
        if (tmr_zero) begin
          state_d  = RECOVER;
          tmr_load = 1'b1;
          tmr_val  = LD_REC;
        end
      end
      RECOVER: begin
        if (tmr_zero) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    pins_d = pins_for(state_d, rw_d);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clkAD) begin
    if (resetAD) begin
      state_q   <= IDLE;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      bus_out_q <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pins_q    <= PINS_IDLE;
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      bus_out_q <= bus_out_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pins_q    <= pins_d;
    end
  end

  assign bus_out = bus_out_q;
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign CS      = pins_q.cs;
  assign RD      = pins_q.rd;
  assign WR      = pins_q.wr;
  assign AD      = pins_q.ad;
  assign DIR     = pins_q.dir;

endmodule

// File: tb/tb_ad_bus_cycle_seq.sv
// Bench for ad_bus_cycle_seq: one instance with default timing and one with a
// swept timing set share the same stimulus; a cycle-level expectation queue per
// instance is filled when a request is accepted and drained by a monitor.
module tb_ad_bus_cycle_seq;
  import ad_bus_pkg::cycle_len;

  localparam int AS0 = 2, TA0 = 1, DS0 = 4, REC0 = 2;
  localparam int AS1 = 1, TA1 = 3, DS1 = 1, REC1 = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       rw;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] bus_in;

  logic [7:0] bus_out_v [2];
  logic [7:0] rdata_v   [2];
  logic       busy_v    [2];
  logic       done_v    [2];
  logic       cs_v      [2];
  logic       rd_v      [2];
  logic       wr_v      [2];
  logic       ad_v      [2];
  logic       dir_v     [2];

  int checks_total  = 0;
  int checks_passed = 0;
  bit mon_en        = 1'b0;
  bit rst_last      = 1'b1;

  // One expected cycle: pins {cs,rd,wr,ad,dir}, handshake, bus value, capture.
  typedef struct packed {
    logic [4:0] pins;
    logic       busy;
    logic       done;
    logic       load_bus;
    logic [7:0] bus_val;
    logic       capture;
  } exp_t;

  exp_t       q0 [$];
  exp_t       q1 [$];
  exp_t       cur       [2];
  logic [7:0] busout_m  [2];
  logic [7:0] rdata_m   [2];
  logic       ad_prev   [2];
  logic       strb_prev [2];

  always #5 clk = ~clk;

  ad_bus_cycle_seq #(
    .DATA_W (8), .T_AS (AS0), .T_TA (TA0), .T_DS (DS0), .T_REC (REC0)
  ) u_dut0 (
    .clkAD (clk), .resetAD (rst), .start (start), .rw (rw),
    .addr (addr), .wdata (wdata), .bus_in (bus_in),
    .bus_out (bus_out_v[0]), .rdata (rdata_v[0]), .busy (busy_v[0]), .done (done_v[0]),
    .CS (cs_v[0]), .RD (rd_v[0]), .WR (wr_v[0]), .AD (ad_v[0]), .DIR (dir_v[0])
  );

  ad_bus_cycle_seq #(
    .DATA_W (8), .T_AS (AS1), .T_TA (TA1), .T_DS (DS1), .T_REC (REC1)
  ) u_dut1 (
    .clkAD (clk), .resetAD (rst), .start (start), .rw (rw),
    .addr (addr), .wdata (wdata), .bus_in (bus_in),
    .bus_out (bus_out_v[1]), .rdata (rdata_v[1]), .busy (busy_v[1]), .done (done_v[1]),
    .CS (cs_v[1]), .RD (rd_v[1]), .WR (wr_v[1]), .AD (ad_v[1]), .DIR (dir_v[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t idle_entry(logic d);
    exp_t e;
    e.pins     = 5'b11110;
    e.busy     = 1'b0;
    e.done     = d;
    e.load_bus = 1'b0;
    e.bus_val  = 8'h00;
    e.capture  = 1'b0;
    return e;
  endfunction

  task automatic push_exp(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic pop_exp(input int d, output exp_t e);
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
  endtask

  task automatic add_phase(input int d, input logic [4:0] pins, input int n,
                           input logic [7:0] bv, input logic cap);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pins     = pins;
      e.busy     = 1'b1;
      e.done     = 1'b0;
      e.load_bus = 1'b1;
      e.bus_val  = bv;
      e.capture  = cap;
      push_exp(d, e);
    end
  endtask

  // Whole bus cycle as a list of phases, each lasting its configured width.
  task automatic build_cycle(input int d, input logic r, input logic [7:0] a, input logic [7:0] w);
    int as_w, ta_w, ds_w, rec_w;
    as_w  = (d == 0) ? AS0  : AS1;
    ta_w  = (d == 0) ? TA0  : TA1;
    ds_w  = (d == 0) ? DS0  : DS1;
    rec_w = (d == 0) ? REC0 : REC1;
    add_phase(d, 5'b01101, 1, a, 1'b0);
    add_phase(d, 5'b01001, as_w, a, 1'b0);
    add_phase(d, 5'b01101, 1, a, 1'b0);
    add_phase(d, {4'b1111, ~r}, ta_w, w, 1'b0);
    add_phase(d, r ? 5'b00110 : 5'b01011, ds_w, w, 1'b0);
    add_phase(d, {4'b0111, ~r}, 1, w, r);
    add_phase(d, 5'b11110, rec_w, w, 1'b0);
    push_exp(d, idle_entry(1'b1));
  endtask

  // Reference model: decides acceptance and advances the expected cycle.
  always @(posedge clk) begin
    rst_last <= rst;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        if (d == 0) q0.delete();
        else        q1.delete();
        cur[d]      = idle_entry(1'b0);
        busout_m[d] = 8'h00;
        rdata_m[d]  = 8'h00;
      end else begin
        if (qsize(d) == 0 && start) build_cycle(d, rw, addr, wdata);
        if (qsize(d) > 0) pop_exp(d, cur[d]);
        else              cur[d] = idle_entry(1'b0);
        if (cur[d].load_bus) busout_m[d] = cur[d].bus_val;
        if (cur[d].capture)  rdata_m[d]  = bus_in;
      end
    end
  end

  // Monitor: compares every visible output against the model mid-cycle.
  always @(negedge clk) begin
    logic [4:0] act;
    logic       viol;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        act = {cs_v[d], rd_v[d], wr_v[d], ad_v[d], dir_v[d]};
        checkOutput($sformatf("pins_busy_done dut%0d", d),
                    {25'd0, act, busy_v[d], done_v[d]},
                    {25'd0, cur[d].pins, cur[d].busy, cur[d].done});
        checkOutput($sformatf("bus_out dut%0d", d), {24'd0, bus_out_v[d]}, {24'd0, busout_m[d]});
        checkOutput($sformatf("rdata dut%0d", d), {24'd0, rdata_v[d]}, {24'd0, rdata_m[d]});
        viol = (dir_v[d] & ~rd_v[d]) | (~wr_v[d] & ~rd_v[d]);
        if (ad_v[d] != ad_prev[d] && !rst_last && !(wr_v[d] & rd_v[d] & strb_prev[d])) viol = 1'b1;
        checkOutput($sformatf("strobe_rules dut%0d", d), {31'd0, viol}, 32'd0);
        ad_prev[d]   = ad_v[d];
        strb_prev[d] = wr_v[d] & rd_v[d];
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One-cycle start pulse with the request fields set alongside it.
  task automatic applyStimulus(input logic r, input logic [7:0] a, input logic [7:0] w);
    @(posedge clk);
    #2;
    start = 1'b1;
    rw    = r;
    addr  = a;
    wdata = w;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  // Directed scenarios followed by a randomized stretch.
  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    rw     = 1'b0;
    addr   = 8'h00;
    wdata  = 8'h00;
    bus_in = 8'h00;
    for (int d = 0; d < 2; d++) begin
      ad_prev[d]   = 1'b1;
      strb_prev[d] = 1'b1;
    end
    @(posedge clk);
    #2;
    mon_en = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(20);

    $display("[TB] write cycle");
    applyStimulus(1'b0, 8'h0A, 8'h5C);
    wait_cycles(20);
    checkOutput("write leaves rdata", {24'd0, rdata_v[0]}, 32'h0);

    $display("[TB] read cycle");
    bus_in = 8'hA3;
    applyStimulus(1'b1, 8'h07, 8'h11);
    wait_cycles(20);
    checkOutput("read capture dut0", {24'd0, rdata_v[0]}, 32'hA3);
    checkOutput("read capture dut1", {24'd0, rdata_v[1]}, 32'hA3);
    bus_in = 8'h00;

    $display("[TB] start while busy");
    applyStimulus(1'b0, 8'h33, 8'h44);
    wait_cycles(2);
    start = 1'b1; rw = 1'b1; addr = 8'hEE; wdata = 8'hFF;
    wait_cycles(3);
    start = 1'b0;
    wait_cycles(20);

    $display("[TB] reset mid write");
    applyStimulus(1'b0, 8'h5A, 8'hC3);
    wait_cycles(6);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    checkOutput("reset clears rdata", {24'd0, rdata_v[0]}, 32'h0);
    checkOutput("reset drops busy", {31'd0, busy_v[0]}, 32'h0);
    applyStimulus(1'b0, 8'h21, 8'h9E);
    wait_cycles(20);

    $display("[TB] back-to-back");
    start = 1'b1;
    for (int i = 0; i < 3 * int'(cycle_len(AS0, TA0, DS0, REC0)); i++) begin
      rw     = 1'($urandom_range(0, 1));
      addr   = 8'($urandom);
      wdata  = 8'($urandom);
      bus_in = 8'($urandom);
      wait_cycles(1);
    end
    start = 1'b0;
    wait_cycles(20);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      start  = ($urandom_range(0, 3) == 0);
      rw     = 1'($urandom_range(0, 1));
      addr   = 8'($urandom);
      wdata  = 8'($urandom);
      bus_in = 8'($urandom);
      rst    = ($urandom_range(0, 199) == 0);
      wait_cycles(1);
    end
    start = 1'b0;
    rst   = 1'b0;
    wait_cycles(20);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
